// File: rtl/cpu_clk_sequencer_if.sv
// Board-side bundle for cpu_clk_sequencer: debounced controls, breakpoint
// inputs and the generated CPU clock with its status outputs.
// master: board/bench side that drives controls. slave: the sequencer.
interface cpu_clk_sequencer_if;
   logic        StepBtn;
   logic        BurstBtn;
   logic        RunSw;
   logic        HaltReq;
   logic        BkptEn;
   logic [31:0] PC;
   logic [31:0] BkptAddr;
   logic        CPUCLK;
   logic [31:0] CycleCount;
   logic [1:0]  State;
   logic        Running;
   logic        Halted;

   modport master (
      output StepBtn, BurstBtn, RunSw, HaltReq, BkptEn, PC, BkptAddr,
      input  CPUCLK, CycleCount, State, Running, Halted
   );

   modport slave (
      input  StepBtn, BurstBtn, RunSw, HaltReq, BkptEn, PC, BkptAddr,
      output CPUCLK, CycleCount, State, Running, Halted
   );
endinterface

// File: rtl/cpu_clk_sequencer.sv
// CPU clock sequencer: derives a full-pulse CPU clock from BasysCLK in
// single-step, burst, free-run and halt modes. Every CPU cycle is a complete
// high phase followed by a complete low phase.
// Optional breakpoint comparator: define CPU_CLK_BKPT_EN.
module cpu_clk_sequencer #(
   parameter int unsigned RUN_HALF  = 50000000,
   parameter int unsigned STEP_HALF = 8,
   parameter int unsigned BURST_LEN = 16
) (
   input logic                BasysCLK,
   input logic                Reset,
   cpu_clk_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StHigh   = 2'd1,
      StLow    = 2'd2,
      StHalted = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      ModeStep  = 2'd0,
      ModeBurst = 2'd1,
      ModeRun   = 2'd2
   } mode_e;

   localparam logic [31:0] RunLast  = 32'(RUN_HALF - 1);
   localparam logic [31:0] StepLast = 32'(STEP_HALF - 1);
   localparam logic [31:0] BurstLen = 32'(BURST_LEN);

   state_e      state_q, state_d;
   mode_e       mode_q, mode_d;
   logic [31:0] phase_q, phase_d;
   logic [31:0] remaining_q, remaining_d;
   logic [31:0] cycle_count_q, cycle_count_d;
   logic        halt_pend_q, halt_pend_d;
   logic        step_prev_q, burst_prev_q;
   logic        cpuclk_q;

   logic step_rise, burst_rise, halt_now, phase_last, bkpt_hit;

   assign step_rise  = bus.StepBtn & ~step_prev_q;
   assign burst_rise = bus.BurstBtn & ~burst_prev_q;
   // A request arriving this cycle counts the same as one already pending.
   assign halt_now   = halt_pend_q | bus.HaltReq;
   assign phase_last = (phase_q == ((mode_q == ModeRun) ? RunLast : StepLast));

`ifdef CPU_CLK_BKPT_EN
   assign bkpt_hit = bus.BkptEn & (bus.PC == bus.BkptAddr);
`else
   logic unused_bkpt_inputs;
   assign unused_bkpt_inputs = ^{bus.BkptEn, bus.PC, bus.BkptAddr};
   assign bkpt_hit = 1'b0;
`endif

   // State register and datapath registers, synchronous reset.
   always_ff @(posedge BasysCLK) begin
      if (Reset) begin
         state_q       <= StIdle;
         mode_q        <= ModeStep;
         phase_q       <= '0;
         remaining_q   <= '0;
         cycle_count_q <= '0;
         halt_pend_q   <= 1'b0;
         step_prev_q   <= 1'b0;
         burst_prev_q  <= 1'b0;
         cpuclk_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         phase_q       <= phase_d;
         remaining_q   <= remaining_d;
         cycle_count_q <= cycle_count_d;
         halt_pend_q   <= halt_pend_d;
         step_prev_q   <= bus.StepBtn;
         burst_prev_q  <= bus.BurstBtn;
         cpuclk_q      <= (state_d == StHigh);
      end
   end

   // Next-state logic; button edges outside IDLE/HALTED are simply dropped.
   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      phase_d       = phase_q;
      remaining_d   = remaining_q;
      cycle_count_d = cycle_count_q;
      case (state_q)
         StIdle: begin
            phase_d = '0;
            if (halt_now) begin
               state_d = StHalted;
            end else if (bus.RunSw) begin
               state_d = StHigh;
               mode_d  = ModeRun;
            end else if (burst_rise) begin
               state_d     = StHigh;
               mode_d      = ModeBurst;
               remaining_d = BurstLen;
            end else if (step_rise) begin
               state_d     = StHigh;
               mode_d      = ModeStep;
               remaining_d = 32'd1;
            end
         end
         StHigh: begin
            if (phase_last) begin
               state_d = StLow;
               phase_d = '0;
            end else begin
               phase_d = phase_q + 32'd1;
            end
         end
         StLow: begin
            if (phase_last) begin
               // Cycle boundary: the only point a new pulse may start.
               phase_d = '0;
               if (halt_now || bkpt_hit) begin
                  state_d = StHalted;
               end else if (mode_q == ModeRun && bus.RunSw) begin
                  state_d = StHigh;
               end else if (mode_q != ModeRun && remaining_q > 32'd1) begin
                  state_d     = StHigh;
                  remaining_d = remaining_q - 32'd1;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               phase_d = phase_q + 32'd1;
            end
         end
         StHalted: begin
            phase_d = '0;
            if (step_rise) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (state_d == StHigh && state_q != StHigh) begin
         cycle_count_d = cycle_count_q + 32'd1;
      end
      halt_pend_d = (state_d == StHalted && state_q != StHalted) ? 1'b0 : halt_now;
   end

   // Outputs decoded from registered state.
   always_comb begin
      bus.CPUCLK     = cpuclk_q;
      bus.CycleCount = cycle_count_q;
      bus.State      = state_q;
      bus.Running    = (state_q == StHigh) || (state_q == StLow);
      bus.Halted     = (state_q == StHalted);
   end

endmodule

// File: tb/tb_cpu_clk_sequencer.sv
// Directed bench for cpu_clk_sequencer with RUN_HALF=3, STEP_HALF=2,
// BURST_LEN=4. CPUCLK waveforms are captured one bit per BasysCLK cycle
// (bit 0 = first cycle after the stimulus change) and compared to
// hand-derived patterns.
module tb_cpu_clk_sequencer;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [31:0] pat;

   cpu_clk_sequencer_if bus ();

   cpu_clk_sequencer #(
      .RUN_HALF  (3),
      .STEP_HALF (2),
      .BURST_LEN (4)
   ) dut (
      .BasysCLK (clk),
      .Reset    (rst),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) tick();
      rst = 1'b0;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b0;
      bus.StepBtn  = 1'b0;
      bus.BurstBtn = 1'b0;
      bus.RunSw    = 1'b0;
      bus.HaltReq  = 1'b0;
      bus.BkptEn   = 1'b0;
      bus.PC       = 32'h0;
      bus.BkptAddr = 32'h0;

      // 1. Reset state
      do_reset(3);
      chk("rst_cpuclk", 32'(bus.CPUCLK), 32'd0);
      chk("rst_count", bus.CycleCount, 32'd0);
      chk("rst_state", 32'(bus.State), 32'd0);
      chk("rst_running", 32'(bus.Running), 32'd0);
      chk("rst_halted", 32'(bus.Halted), 32'd0);

      // 2. Single step, button held 20 cycles: one pulse only
      do_reset(1);
      bus.StepBtn = 1'b1;
      pat = '0;
      for (int i = 0; i < 20; i++) begin
         tick();
         pat[i] = bus.CPUCLK;
         if (i == 0) begin
            chk("step_first_state", 32'(bus.State), 32'd1);
            chk("step_first_running", 32'(bus.Running), 32'd1);
            chk("step_first_count", bus.CycleCount, 32'd1);
         end
      end
      chk("step_pattern", pat, 32'h0000_0003);
      chk("step_count", bus.CycleCount, 32'd1);
      chk("step_state", 32'(bus.State), 32'd0);
      bus.StepBtn = 1'b0;

      // 3. Burst of 4, step press mid-burst ignored
      do_reset(1);
      bus.BurstBtn = 1'b1;
      pat = '0;
      for (int i = 0; i < 16; i++) begin
         tick();
         pat[i] = bus.CPUCLK;
         if (i == 5) bus.StepBtn = 1'b1;
      end
      chk("burst_pattern", pat, 32'h0000_3333);
      tick();
      chk("burst_end_state", 32'(bus.State), 32'd0);
      chk("burst_count", bus.CycleCount, 32'd4);
      repeat (6) tick();
      chk("burst_step_ignored", bus.CycleCount, 32'd4);
      chk("burst_idle", 32'(bus.State), 32'd0);
      bus.BurstBtn = 1'b0;
      bus.StepBtn  = 1'b0;

      // 4. Free-run for 14 cycles, in-flight pulse completes
      do_reset(1);
      bus.RunSw = 1'b1;
      pat = '0;
      for (int i = 0; i < 20; i++) begin
         tick();
         pat[i] = bus.CPUCLK;
         if (i == 13) bus.RunSw = 1'b0;
      end
      chk("run_pattern", pat, 32'h0000_71C7);
      chk("run_count", bus.CycleCount, 32'd3);
      chk("run_state", 32'(bus.State), 32'd0);

      // 5. Halt request during 2nd high phase
      do_reset(1);
      bus.RunSw = 1'b1;
      pat = '0;
      for (int i = 0; i < 15; i++) begin
         bus.HaltReq = (i == 7);
         tick();
         pat[i] = bus.CPUCLK;
      end
      bus.HaltReq = 1'b0;
      chk("halt_pattern", pat, 32'h0000_01C7);
      chk("halt_state", 32'(bus.State), 32'd3);
      chk("halt_halted", 32'(bus.Halted), 32'd1);
      chk("halt_running", 32'(bus.Running), 32'd0);
      chk("halt_cpuclk", 32'(bus.CPUCLK), 32'd0);
      chk("halt_count", bus.CycleCount, 32'd2);
      bus.RunSw = 1'b0;
      tick();
      chk("halt_hold", 32'(bus.State), 32'd3);
      bus.StepBtn = 1'b1;
      tick();
      chk("halt_exit_state", 32'(bus.State), 32'd0);
      chk("halt_exit_count", bus.CycleCount, 32'd2);
      tick();
      chk("halt_exit_no_pulse", 32'(bus.State), 32'd0);
      chk("halt_exit_count2", bus.CycleCount, 32'd2);
      bus.StepBtn = 1'b0;

      // 6. Breakpoint at end of 1st burst pulse
      do_reset(1);
      bus.BkptEn   = 1'b1;
      bus.BkptAddr = 32'h0000_000C;
      bus.BurstBtn = 1'b1;
      pat = '0;
      for (int i = 0; i < 17; i++) begin
         bus.PC = (i == 4) ? 32'h0000_000C : 32'h0;
         tick();
         pat[i] = bus.CPUCLK;
      end
      bus.PC       = 32'h0;
      bus.BurstBtn = 1'b0;
`ifdef CPU_CLK_BKPT_EN
      chk("bkpt_pattern", pat, 32'h0000_0003);
      chk("bkpt_state", 32'(bus.State), 32'd3);
      chk("bkpt_count", bus.CycleCount, 32'd1);
`else
      chk("bkpt_pattern", pat, 32'h0000_3333);
      chk("bkpt_state", 32'(bus.State), 32'd0);
      chk("bkpt_count", bus.CycleCount, 32'd4);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_clk_sequencer.md
Name: cpu_clk_sequencer

Overview:
Generates the board-side CPU clock for the pipeline CPU from the Basys system clock. Supports four modes: single-step, fixed-length burst, free-run, and halt. Sits between the debounced board buttons/switches and the CPU clock net. Sequences every CPU cycle as a full high+low pulse so no truncated clock edge ever reaches the pipeline.

Parameters:
RUN_HALF, 50000000, BasysCLK cycles per CPUCLK half-period in free-run mode (1 Hz at 100 MHz).
STEP_HALF, 8, BasysCLK cycles per CPUCLK half-period for step and burst pulses.
BURST_LEN, 16, number of CPU cycles issued per burst request (>=1).

Ports:
BasysCLK  in  1  system clock; the only clock in the block.
Reset  in  1  synchronous, active-high reset.
StepBtn  in  1  debounced step button level.
BurstBtn  in  1  debounced burst button level.
RunSw  in  1  free-run switch level.
HaltReq  in  1  halt request from the CPU (halt instruction retired).
BkptEn  in  1  breakpoint enable.
PC  in  32  current CPU program counter.
BkptAddr  in  32  breakpoint address.
CPUCLK  out  1  generated CPU clock, registered.
CycleCount  out  32  number of CPU rising edges since reset.
State  out  2  0=IDLE, 1=HIGH, 2=LOW, 3=HALTED.
Running  out  1  1 in HIGH or LOW.
Halted  out  1  1 in HALTED.

Behaviour:
- Single clock domain: BasysCLK. Reset is synchronous and active-high.
- On Reset: CPUCLK=0, CycleCount=0, State=IDLE, phase counter=0, remaining=0, halt_pend=0, button history regs=0.
- Edge detect: each button is registered every cycle. rise = level & ~prev. Edges outside IDLE/HALTED are discarded, not queued.
- IDLE (CPUCLK=0). Priority order:
  - halt_pend|HaltReq -> HALTED.
  - RunSw=1 -> HIGH, mode=RUN.
  - BurstBtn rise -> HIGH, mode=BURST, remaining=BURST_LEN.
  - StepBtn rise -> HIGH, mode=STEP, remaining=1.
  - A rising input produces CPUCLK=1 at the first edge where the button is sampled high with prev low.
- Entering HIGH: CPUCLK<=1 and CycleCount<=CycleCount+1 on the same edge. CycleCount wraps at 2^32.
- HIGH: CPUCLK held 1 for exactly H cycles (H=RUN_HALF in RUN, else STEP_HALF), then -> LOW with CPUCLK<=0.
- LOW: CPUCLK held 0 for exactly H cycles. On the last LOW cycle (the cycle boundary), priority order:
  - halt_pend or breakpoint hit -> HALTED.
  - mode=RUN and RunSw=1 -> HIGH.
  - mode in {STEP,BURST} and remaining>1 -> HIGH, remaining-1.
  - else -> IDLE.
- halt_pend is set by HaltReq=1 in any state. It takes effect only at the cycle boundary (or immediately in IDLE) and clears on entry to HALTED.
- RunSw dropping mid-cycle: the current high+low pulse completes, then IDLE.
- HALTED: CPUCLK=0. Only StepBtn rise exits, to IDLE, without issuing a pulse. HaltReq still high at that point re-enters HALTED on the next cycle.
- Reset mid-pulse: CPUCLK=0 on the next edge. No partial-pulse completion.
- Running and Halted are decoded combinationally from the registered State.
- Phase counter: 32-bit, compares against H-1, reloads 0 on every phase change.

Optional Feature:
CPU_CLK_BKPT_EN.
- Defined: breakpoint hit = BkptEn & (PC==BkptAddr), sampled at the cycle boundary in LOW. A hit forces HALTED instead of issuing the next pulse.
- Undefined: no comparator is built. BkptEn, PC and BkptAddr are present but ignored; breakpoint hit is constant 0.

Test Plan:
Bench overrides: RUN_HALF=3, STEP_HALF=2, BURST_LEN=4.
1. Reset held 3 cycles -> CPUCLK=0, CycleCount=0, State=0, Running=0, Halted=0.
2. StepBtn raised and held 20 cycles -> exactly one pulse (CPUCLK 1 for 2 cycles, 0 for 2), CycleCount=1, State back to 0; no second pulse while held.
3. BurstBtn rise -> 4 pulses, period 4 BasysCLK cycles, CycleCount=4, back to IDLE. StepBtn rise during the burst -> ignored, CycleCount stays 4.
4. RunSw=1 for 14 cycles then 0 -> pulses with period 6; the pulse in progress at deassert completes; CycleCount=3; IDLE.
5. RunSw=1, HaltReq pulsed during the 2nd HIGH phase -> the 2nd pulse completes, State=3, Halted=1, CPUCLK=0, CycleCount=2. StepBtn rise -> State=0, CycleCount unchanged.
6. CPU_CLK_BKPT_EN defined, BkptEn=1, BkptAddr=0x0000000C, PC=0x0000000C at the end of the 1st burst pulse -> HALTED, CycleCount=1. Macro undefined, same stimulus -> all 4 pulses issue.
